// File: rtl/memory_port_crossbar.sv
// Address-decoded crossbar from core request ports to memory targets.
// Each target has its own round-robin arbiter, and unmapped accesses take a one-cycle error path.
module memory_port_crossbar #(
    parameter int unsigned PORT_COUNT   = 2,
    parameter int unsigned TARGET_COUNT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [32*PORT_COUNT-1:0]     m_address,
    input  logic [4*PORT_COUNT-1:0]      m_byteSelect,
    input  logic [PORT_COUNT-1:0]        m_enable,
    input  logic [PORT_COUNT-1:0]        m_writeEnable,
    input  logic [32*PORT_COUNT-1:0]     m_dataWrite,
    output logic [32*PORT_COUNT-1:0]     m_dataRead,
    output logic [PORT_COUNT-1:0]        m_busy,
    output logic [PORT_COUNT-1:0]        m_error,
    output logic [28*TARGET_COUNT-1:0]   t_address,
    output logic [4*TARGET_COUNT-1:0]    t_byteSelect,
    output logic [TARGET_COUNT-1:0]      t_enable,
    output logic [TARGET_COUNT-1:0]      t_writeEnable,
    output logic [32*TARGET_COUNT-1:0]   t_dataWrite,
    input  logic [32*TARGET_COUNT-1:0]   t_dataRead,
    input  logic [TARGET_COUNT-1:0]      t_busy
);
    localparam int unsigned GW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

    typedef enum logic {Idle, Active} stateType;

    stateType              state      [TARGET_COUNT];
    stateType              stateNext  [TARGET_COUNT];
    logic [GW-1:0]         grant      [TARGET_COUNT];
    logic [GW-1:0]         grantNext  [TARGET_COUNT];
    logic [GW-1:0]         rrPtr      [TARGET_COUNT];
    logic [GW-1:0]         rrPtrNext  [TARGET_COUNT];
    logic [PORT_COUNT-1:0] errPending;
    logic [PORT_COUNT-1:0] errPendingNext;
    logic [PORT_COUNT-1:0] unmapped;

    logic [31:0] mAddr  [PORT_COUNT];
    logic [31:0] mWrite [PORT_COUNT];
    logic [3:0]  mBsel  [PORT_COUNT];
    logic [31:0] mRead  [PORT_COUNT];

    function automatic logic [GW-1:0] nextPort(input logic [GW-1:0] p);
        logic [GW:0] s;
        s = {1'b0, p} + (GW+1)'(1);
        nextPort = (s >= (GW+1)'(PORT_COUNT)) ? '0 : s[GW-1:0];
    endfunction

    // Unpack per-port buses so the granted port can be selected by index.
    always_comb begin : unpackPorts
        for (int p = 0; p < PORT_COUNT; p++) begin
            mAddr[p]  = m_address[32*p +: 32];
            mWrite[p] = m_dataWrite[32*p +: 32];
            mBsel[p]  = m_byteSelect[4*p +: 4];
            m_dataRead[32*p +: 32] = mRead[p];
        end
    end

    // Unmapped decode; errPending marks the first cycle of each unmapped request.
    always_comb begin : decodeUnmapped
        for (int p = 0; p < PORT_COUNT; p++) begin
            unmapped[p]       = m_enable[p] && (32'(mAddr[p][31:28]) >= TARGET_COUNT);
            errPendingNext[p] = unmapped[p] && !errPending[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < TARGET_COUNT; t++) begin
                state[t] <= Idle;
                grant[t] <= '0;
                rrPtr[t] <= '0;
            end
            errPending <= '0;
        end else begin
            for (int t = 0; t < TARGET_COUNT; t++) begin
                state[t] <= stateNext[t];
                grant[t] <= grantNext[t];
                rrPtr[t] <= rrPtrNext[t];
            end
            errPending <= errPendingNext;
        end
    end

    // Per-target arbitration, forwarding and completion steering.
    always_comb begin : crossbarPaths
        logic          found;
        logic [GW:0]   sum;
        logic [GW-1:0] pIdx;
        logic [GW-1:0] g;
        found = 1'b0;
        sum   = '0;
        pIdx  = '0;
        g     = '0;
        for (int t = 0; t < TARGET_COUNT; t++) begin
            stateNext[t] = state[t];
            grantNext[t] = grant[t];
            rrPtrNext[t] = rrPtr[t];
        end
        for (int p = 0; p < PORT_COUNT; p++) begin
            mRead[p] = '1;
        end
        t_address     = '0;
        t_byteSelect  = '0;
        t_enable      = '0;
        t_writeEnable = '0;
        t_dataWrite   = '0;
        m_busy        = '1;
        m_error       = '0;

        for (int t = 0; t < TARGET_COUNT; t++) begin
            if (state[t] == Idle) begin
                found = 1'b0;
                for (int i = 0; i < PORT_COUNT; i++) begin
                    sum = {1'b0, rrPtr[t]} + (GW+1)'(i);
                    if (sum >= (GW+1)'(PORT_COUNT)) begin
                        sum = sum - (GW+1)'(PORT_COUNT);
                    end
                    pIdx = sum[GW-1:0];
                    if (!found && m_enable[pIdx] && mAddr[pIdx][31:28] == 4'(t)) begin
                        found        = 1'b1;
                        grantNext[t] = pIdx;
                        stateNext[t] = Active;
                    end
                end
            end else begin
                g = grant[t];
                t_enable[t]           = m_enable[g];
                t_writeEnable[t]      = m_writeEnable[g];
                t_address[28*t +: 28] = mAddr[g][27:0];
                t_byteSelect[4*t +: 4] = mBsel[g];
                t_dataWrite[32*t +: 32] = mWrite[g];
                // Completion or abort both release the target and rotate priority.
                if (!m_enable[g] || !t_busy[t]) begin
                    stateNext[t] = Idle;
                    rrPtrNext[t] = nextPort(g);
                end
                if (m_enable[g] && !t_busy[t]) begin
                    m_busy[g] = 1'b0;
                    mRead[g]  = t_dataRead[32*t +: 32];
                end
            end
        end

        for (int p = 0; p < PORT_COUNT; p++) begin
            if (errPending[p] && unmapped[p]) begin
                m_busy[p]  = 1'b0;
                m_error[p] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_memory_port_crossbar.sv
// Bench for memory_port_crossbar: directed vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_memory_port_crossbar;
    localparam int PC = 2;
    localparam int TC = 2;
    localparam logic [63:0] ONES = {64{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   m_address, m_dataWrite, m_dataRead;
    logic [7:0]    m_byteSelect;
    logic [1:0]    m_enable, m_writeEnable, m_busy, m_error;
    logic [55:0]   t_address;
    logic [7:0]    t_byteSelect;
    logic [1:0]    t_enable, t_writeEnable, t_busy;
    logic [63:0]   t_dataWrite, t_dataRead;

    int checks   = 0;
    int failures = 0;

    memory_port_crossbar #(.PORT_COUNT(PC), .TARGET_COUNT(TC)) dut (
        .clk(clk), .rst(rst),
        .m_address(m_address), .m_byteSelect(m_byteSelect), .m_enable(m_enable),
        .m_writeEnable(m_writeEnable), .m_dataWrite(m_dataWrite), .m_dataRead(m_dataRead),
        .m_busy(m_busy), .m_error(m_error),
        .t_address(t_address), .t_byteSelect(t_byteSelect), .t_enable(t_enable),
        .t_writeEnable(t_writeEnable), .t_dataWrite(t_dataWrite),
        .t_dataRead(t_dataRead), .t_busy(t_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  en, we;
        logic [63:0] addr, wdata;
        logic [7:0]  bsel;
        logic [1:0]  tbusy;
        logic [63:0] tdata;
        logic [1:0]  xBusy, xErr;
        logic [63:0] xRdata;
        logic [1:0]  xTen, xTwe;
        logic [55:0] xTaddr;
        logic [63:0] xTwdata;
        logic [7:0]  xTbsel;
    } vecT;

    vecT vecs [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyVec(input vecT v);
        @(posedge clk);
        #1;
        m_enable = v.en; m_writeEnable = v.we; m_address = v.addr;
        m_dataWrite = v.wdata; m_byteSelect = v.bsel;
        t_busy = v.tbusy; t_dataRead = v.tdata;
        @(negedge clk);
        check({v.name, "_mside"}, 128'({m_busy, m_error, m_dataRead}), 128'({v.xBusy, v.xErr, v.xRdata}));
        check({v.name, "_tside"}, 128'({t_enable, t_writeEnable, t_address, t_byteSelect}),
              128'({v.xTen, v.xTwe, v.xTaddr, v.xTbsel}));
        check({v.name, "_twdata"}, 128'(t_dataWrite), 128'(v.xTwdata));
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            m_enable = '0; t_busy = '0;
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1; m_enable = '0; t_busy = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model state: per target owner/priority, per port error phase.
    bit mAct [TC]; int mOwn [TC]; int mPtr [TC]; bit mErr [PC];
    bit nAct [TC]; int nOwn [TC]; int nPtr [TC]; bit nErr [PC];
    bit done [PC]; bit pend [PC];

    function automatic int tgtOf(input int p);
        logic [31:0] a;
        a = 32'(m_address >> (32*p));
        return int'(a[31:28]);
    endfunction

    task automatic modelEval();
        logic [1:0]  eBusy, eErr, eTen, eTwe;
        logic [63:0] eRd, eTwd;
        logic [55:0] eTa;
        logic [7:0]  eTbs;
        int o, best, bestDist, d;
        bit unm;
        eBusy = '1; eErr = '0; eTen = '0; eTwe = '0;
        eRd = ONES; eTwd = '0; eTa = '0; eTbs = '0;
        for (int p = 0; p < PC; p++) done[p] = 1'b0;
        for (int t = 0; t < TC; t++) begin
            nAct[t] = mAct[t]; nOwn[t] = mOwn[t]; nPtr[t] = mPtr[t];
            if (mAct[t]) begin
                o = mOwn[t];
                eTen[t] = m_enable[o];
                eTwe[t] = m_writeEnable[o];
                eTa[28*t +: 28]  = m_address[32*o +: 28];
                eTwd[32*t +: 32] = m_dataWrite[32*o +: 32];
                eTbs[4*t +: 4]   = m_byteSelect[4*o +: 4];
                if (m_enable[o] && !t_busy[t]) begin
                    eBusy[o] = 1'b0;
                    eRd[32*o +: 32] = t_dataRead[32*t +: 32];
                    done[o] = 1'b1;
                end
                if (!m_enable[o] || !t_busy[t]) begin
                    nAct[t] = 1'b0;
                    nPtr[t] = (o + 1) % PC;
                end
            end else begin
                best = -1; bestDist = PC;
                for (int p = 0; p < PC; p++) begin
                    d = (p - mPtr[t] + PC) % PC;
                    if (m_enable[p] && tgtOf(p) == t && d < bestDist) begin
                        best = p; bestDist = d;
                    end
                end
                if (best >= 0) begin
                    nAct[t] = 1'b1; nOwn[t] = best;
                end
            end
        end
        for (int p = 0; p < PC; p++) begin
            unm = m_enable[p] && tgtOf(p) >= TC;
            if (unm && mErr[p]) begin
                eBusy[p] = 1'b0; eErr[p] = 1'b1; done[p] = 1'b1;
            end
            nErr[p] = unm && !mErr[p];
        end
        check("rand_mside", 128'({m_busy, m_error, m_dataRead}), 128'({eBusy, eErr, eRd}));
        check("rand_tside", 128'({t_enable, t_writeEnable, t_address, t_byteSelect}),
              128'({eTen, eTwe, eTa, eTbs}));
        check("rand_twdata", 128'(t_dataWrite), 128'(eTwd));
    endtask

    initial begin
        logic [3:0] order;
        int nDone, waitCnt;

        rst = 1'b1;
        m_address = '0; m_dataWrite = '0; m_byteSelect = '0;
        m_enable = '0; m_writeEnable = '0;
        t_busy = '0; t_dataRead = '0;

        vecs[0]  = '{"idle0", 2'b00, 2'b00, 64'h0, 64'h0, 8'h00, 2'b00, 64'h0,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[1]  = '{"rd_req", 2'b01, 2'b00, 64'h0000_0000_0000_0010, 64'h0, 8'h0F, 2'b00,
                     64'h0000_0000_1234_5678,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[2]  = '{"rd_done", 2'b01, 2'b00, 64'h0000_0000_0000_0010, 64'h0, 8'h0F, 2'b00,
                     64'h0000_0000_1234_5678,
                     2'b10, 2'b00, 64'hFFFF_FFFF_1234_5678, 2'b01, 2'b00,
                     {28'h0, 28'h0000010}, 64'h0, 8'h0F};
        vecs[3]  = '{"idle1", 2'b00, 2'b00, 64'h0, 64'h0, 8'h00, 2'b00, 64'h0,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[4]  = '{"conc_req", 2'b11, 2'b10, 64'h1000_0040_0000_0020, 64'hCAFE_F00D_0000_0000,
                     8'h3F, 2'b11, 64'hAAAA_0001_5555_0000,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[5]  = '{"conc_act", 2'b11, 2'b10, 64'h1000_0040_0000_0020, 64'hCAFE_F00D_0000_0000,
                     8'h3F, 2'b11, 64'hAAAA_0001_5555_0000,
                     2'b11, 2'b00, ONES, 2'b11, 2'b10, {28'h0000040, 28'h0000020},
                     64'hCAFE_F00D_0000_0000, 8'h3F};
        vecs[6]  = '{"conc_done", 2'b11, 2'b10, 64'h1000_0040_0000_0020, 64'hCAFE_F00D_0000_0000,
                     8'h3F, 2'b00, 64'hAAAA_0001_5555_0000,
                     2'b00, 2'b00, 64'hAAAA_0001_5555_0000, 2'b11, 2'b10,
                     {28'h0000040, 28'h0000020}, 64'hCAFE_F00D_0000_0000, 8'h3F};
        vecs[7]  = '{"idle2", 2'b00, 2'b00, 64'h0, 64'h0, 8'h00, 2'b00, 64'h0,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[8]  = '{"unm_req", 2'b10, 2'b00, 64'h3000_0000_0000_0000, 64'h0, 8'h00, 2'b00, 64'h0,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[9]  = '{"unm_done", 2'b10, 2'b00, 64'h3000_0000_0000_0000, 64'h0, 8'h00, 2'b00, 64'h0,
                     2'b01, 2'b10, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};
        vecs[10] = '{"idle3", 2'b00, 2'b00, 64'h0, 64'h0, 8'h00, 2'b00, 64'h0,
                     2'b11, 2'b00, ONES, 2'b00, 2'b00, 56'h0, 64'h0, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 11; i++) applyVec(vecs[i]);

        // Contention on target 1: each access waits two cycles, grants must alternate.
        @(posedge clk);
        #1;
        m_enable = 2'b11; m_writeEnable = '0;
        m_address = 64'h1000_0004_1000_0000;
        t_dataRead = 64'h0BAD_0001_0BAD_0000;
        order = '0; nDone = 0; waitCnt = 0;
        for (int cyc = 0; cyc < 60 && nDone < 4; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            t_busy = '0;
            if (t_enable[1]) t_busy[1] = (waitCnt < 2);
            @(negedge clk);
            if (t_enable[1]) begin
                if (!t_busy[1]) begin
                    check("cont_one_low", 128'($countones(~m_busy)), 128'(1));
                    order[nDone] = m_busy[1] ? 1'b0 : 1'b1;
                    nDone++;
                    waitCnt = 0;
                end else begin
                    check("cont_wait_busy", 128'(m_busy), 128'(2'b11));
                    waitCnt++;
                end
            end
        end
        check("cont_count", 128'(nDone), 128'(4));
        check("cont_order", 128'(order), 128'(4'b1010));
        idleCycles(2);

        // Abort: port 0 drops its request while target 0 is stalling.
        @(posedge clk);
        #1;
        m_enable = 2'b01; m_address = 64'h0000_0000_0000_0100; t_busy = 2'b11;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_active_ten", 128'(t_enable), 128'(2'b01));
        @(posedge clk);
        #1;
        m_enable = 2'b00;
        @(negedge clk);
        check("abort_drop_ten", 128'(t_enable), 128'(2'b00));
        check("abort_drop_busy", 128'(m_busy), 128'(2'b11));
        @(posedge clk);
        #1;
        m_enable = 2'b11; m_address = 64'h0000_0200_0000_0100;
        check("abort_idle_next", 128'({t_enable, t_address}), 128'(0));
        @(posedge clk);
        #1;
        check("abort_rr_port1", 128'({t_enable[0], t_address[27:0]}), 128'({1'b1, 28'h0000200}));
        idleCycles(2);

        // Reset in the middle of an access.
        @(posedge clk);
        #1;
        m_enable = 2'b01; m_address = 64'h0000_0000_0000_0300; t_busy = 2'b11;
        @(posedge clk);
        #1;
        check("rst_pre_ten", 128'(t_enable), 128'(2'b01));
        #2;
        rst = 1'b1;
        #1;
        check("rst_ten", 128'(t_enable), 128'(2'b00));
        check("rst_busy", 128'({m_busy, m_error, m_dataRead}), 128'({2'b11, 2'b00, ONES}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_enable = 2'b11; m_address = 64'h0000_0400_0000_0300;
        @(posedge clk);
        #1;
        check("rst_rr_port0", 128'({t_enable[0], t_address[27:0]}), 128'({1'b1, 28'h0000300}));
        idleCycles(2);

        // Random traffic against the reference model.
        doReset();
        for (int t = 0; t < TC; t++) begin
            mAct[t] = 1'b0; mOwn[t] = 0; mPtr[t] = 0;
        end
        for (int p = 0; p < PC; p++) begin
            mErr[p] = 1'b0; done[p] = 1'b0; pend[p] = 1'b0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(posedge clk);
            if (cyc > 0) begin
                mAct = nAct; mOwn = nOwn; mPtr = nPtr; mErr = nErr;
            end
            #1;
            for (int p = 0; p < PC; p++) begin
                if (done[p]) pend[p] = 1'b0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_address[32*p +: 32]  = {4'($urandom_range(0, 2)), 28'($urandom)};
                        m_dataWrite[32*p +: 32] = $urandom;
                        m_byteSelect[4*p +: 4]  = 4'($urandom);
                        m_writeEnable[p]        = 1'($urandom);
                        pend[p] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end
                m_enable[p] = pend[p];
            end
            t_busy = 2'($urandom);
            t_dataRead = {$urandom, $urandom};
            @(negedge clk);
            modelEval();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_port_crossbar.md
# memory_port_crossbar

Parametrised multi-master, multi-target memory crossbar for the core's memory subsystem. It connects PORT_COUNT core-side request ports, such as instruction fetch, data and debug, to TARGET_COUNT memory-side ports, such as local SRAM and the Wishbone master. Requests are routed by address decoding. Each target has its own round-robin arbiter, and the grant is held for the whole transaction. Unmapped addresses complete with an error response, and independent targets serve different ports concurrently.

## Interface
- PORT_COUNT, 2: number of core-side request ports (1..8)
- TARGET_COUNT, 2: number of targets; target t decodes address[31:28] == t (1..16)
- Per-port vector signals are packed with port p at slice p. Per-target vector signals are packed with target t at slice t.
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- m_address  input  32*PORT_COUNT  request address
- m_byteSelect  input  4*PORT_COUNT  byte lanes
- m_enable  input  PORT_COUNT  request valid; held until completion
- m_writeEnable  input  PORT_COUNT  1 = write
- m_dataWrite  input  32*PORT_COUNT  write data
- m_dataRead  output  32*PORT_COUNT  read data, valid in the completion cycle
- m_busy  output  PORT_COUNT  0 only in the completion cycle
- m_error  output  PORT_COUNT  1 in the completion cycle of an unmapped access
- t_address  output  28*TARGET_COUNT  address[27:0] of the granted port
- t_byteSelect  output  4*TARGET_COUNT  forwarded byte lanes
- t_enable  output  TARGET_COUNT  target access active
- t_writeEnable  output  TARGET_COUNT  forwarded write enable
- t_dataWrite  output  32*TARGET_COUNT  forwarded write data
- t_dataRead  input  32*TARGET_COUNT  target read data
- t_busy  input  TARGET_COUNT  0 while t_enable=1 means the access completes this cycle

## Operation
- **Decode.** port p requests target t when m_enable[p]=1 and m_address[p][31:28]=t<TARGET_COUNT. If the decoded index is ≥TARGET_COUNT, the request is unmapped.
- **Per-target FSM, IDLE → ACTIVE:**
  - In IDLE, when any port requests t, grant the first requester found searching upward (with wrap) from rr_ptr[t]. The grant is registered.
  - In ACTIVE, t_* outputs are driven combinationally from the granted port's inputs, and t_enable = m_enable[grant].
  - Completion occurs when t_enable=1 and t_busy[t]=0. In that cycle m_dataRead[grant]=t_dataRead[t] and m_busy[grant]=0. On the next edge the FSM goes to IDLE and rr_ptr[t] becomes (grant+1) mod PORT_COUNT.
  - Abort: if the granted port drops m_enable while ACTIVE, t_enable falls the same cycle and the FSM returns to IDLE next edge. rr_ptr still advances.
- **Unmapped path, per port, 1-cycle error state:**
  - The first cycle of an unmapped request registers err_pending[p].
  - In the next cycle, if still requested, m_busy[p]=0, m_error[p]=1 and m_dataRead[p]=32'hFFFF_FFFF.
  - err_pending clears after that cycle.
- **Idle/default values.**
  - Ports not in their completion cycle: m_busy=1, m_error=0, m_dataRead=32'hFFFF_FFFF.
  - Targets not ACTIVE: all t_* outputs are 0.
- **Concurrency.**
  - Different targets may be ACTIVE simultaneously, each with a different port.
  - A port holds at most one grant.
  - A port must not change address or data while m_busy=1. The block does not check this.
- **Back-to-back.**
  - After completion the FSM spends one cycle in IDLE before a new grant.
  - A port requesting again right away competes normally; rr_ptr gives the other ports priority.

## Timing
- **Reset, asynchronous.**
  - All FSMs go to IDLE, rr_ptr=0 and err_pending=0.
  - Outputs: t_*=0, m_busy=all 1, m_error=0, m_dataRead=all 1s.
  - Reset mid-transaction drops t_enable immediately. No completion is signalled.
- **Latency.**
  - A request is raised in cycle N. Grant registers at edge N+1, and t_enable=1 during cycle N+1.
  - With a zero-wait target (t_busy=0), completion is in cycle N+1, giving 2-cycle minimum occupancy including the IDLE cycle that follows.
  - Each cycle of t_busy=1 adds one cycle.
- **Unmapped latency.** A request in cycle N completes in cycle N+1.
- **Combinational paths.** m_dataRead and m_busy depend combinationally on t_dataRead and t_busy. There are no other combinational input→output paths except t_* forwarding.

## Test plan
- **Single read.** Port 0 reads 0x0000_0010 on zero-wait target 0 returning 0x1234_5678 -> t_address[0]=0x0000010 and t_enable[0]=1 in cycle 1; m_busy[0]=0 and m_dataRead=0x1234_5678 in cycle 1.
- **Contention.** Ports 0 and 1 both read target 1 continuously, target busy 2 cycles per access -> grants alternate 0,1,0,1. Each access shows m_busy low for exactly one cycle, and the other port's m_busy stays 1.
- **Concurrency.** Port 0 reads target 0 while port 1 writes 0xCAFE_F00D with byteSelect 4'b0011 to target 1 -> both t_enable are high in the same cycle. t_dataWrite[1]=0xCAFE_F00D, t_byteSelect[1]=4'b0011.
- **Unmapped.** TARGET_COUNT=2, port 1 reads 0x3000_0000 -> in cycle 1, m_error[1]=1, m_busy[1]=0, m_dataRead=0xFFFF_FFFF. No t_enable is raised.
- **Abort and reset.** Port 0 drops m_enable during an active access with t_busy=1 -> t_enable drops the same cycle and the FSM is IDLE next edge. Separately, asserting rst mid-access -> all t_enable are 0 and all m_busy are 1 immediately, and a new request after reset is granted to port 0 first.
